// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a word-addressed on-chip SRAM with independent
// read and write burst engines and full per-beat handshakes.
module axi_sram_slave #(
  parameter int unsigned DEPTH_LOG2 = 16,
  parameter              INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  // AR channel
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  // R channel
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // AW channel
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  // W channel
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // B channel
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {R_IDLE, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [31:0] mem [DEPTH];

  // Protection/cache/lock attributes and wid carry no meaning here
  logic unused_attr;
  assign unused_attr = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  assign rresp = 2'b00;

  // Next beat address for FIXED / INCR / WRAP (2'b11 behaves as INCR)
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [3:0]  len,
                                            input logic [1:0]  burst);
    logic [31:0] incr;
    logic [31:0] sum;
    logic [31:0] mask;
    incr = 32'(1) << size;
    sum  = addr + incr;
    mask = ((32'(len) + 32'd1) << size) - 32'd1;
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = (addr & ~mask) | (sum & mask);
      default: next_addr = sum;
    endcase
  endfunction

  // ---------------- read engine ----------------
  r_state_t    r_state, r_next;
  logic [31:0] r_addr;
  logic [3:0]  r_len, r_beat;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic        ar_hs, r_hs, r_last_beat;
  logic        rd_en;
  logic [31:0] rd_addr;

  assign ar_hs       = arvalid & arready;
  assign r_hs        = rvalid & rready;
  assign r_last_beat = (r_beat == r_len);

  // Read next-state and SRAM read request
  always_comb begin
    r_next  = r_state;
    rd_en   = 1'b0;
    rd_addr = r_addr;
    case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          r_next  = R_BURST;
          rd_en   = 1'b1;
          rd_addr = araddr;
        end
      end
      R_BURST: begin
        if (r_hs) begin
          if (r_last_beat) begin
            r_next = R_IDLE;
          end else begin
            rd_en   = 1'b1;
            rd_addr = next_addr(r_addr, r_size, r_len, r_burst);
          end
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Read state, burst context and registered R/AR outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= 4'd0;
      r_addr  <= 32'd0;
      r_len   <= 4'd0;
      r_beat  <= 4'd0;
      r_size  <= 3'd0;
      r_burst <= 2'd0;
    end else begin
      r_state <= r_next;
      arready <= (r_next == R_IDLE);
      rvalid  <= (r_next == R_BURST);
      if (ar_hs) begin
        rid     <= arid;
        r_addr  <= araddr;
        r_len   <= arlen;
        r_size  <= arsize;
        r_burst <= arburst;
        r_beat  <= 4'd0;
        rlast   <= (arlen == 4'd0);
      end else if (r_hs) begin
        if (!r_last_beat) begin
          r_addr <= rd_addr;
          r_beat <= r_beat + 4'd1;
          rlast  <= ((r_beat + 4'd1) == r_len);
        end else begin
          rlast <= 1'b0;
        end
      end
    end
  end

  // SRAM read port; rdata only changes when a new word is requested
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 32'd0;
    end else if (rd_en) begin
      rdata <= mem[rd_addr[DEPTH_LOG2+1:2]];
    end
  end

  // ---------------- write engine ----------------
  w_state_t    w_state, w_next;
  logic [31:0] w_addr;
  logic [3:0]  w_len, w_beat;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic        w_err;
  logic        aw_hs, w_hs, b_hs, w_last_beat, w_err_beat;

  assign aw_hs       = awvalid & awready;
  assign w_hs        = wvalid & wready;
  assign b_hs        = bvalid & bready;
  assign w_last_beat = (w_beat == w_len);
  // wlast must be high exactly on the beat the counter says is final
  assign w_err_beat  = w_last_beat ? ~wlast : wlast;

  // Write next-state
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (aw_hs) w_next = W_DATA;
      W_DATA: if (w_hs && w_last_beat) w_next = W_RESP;
      W_RESP: if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write state, burst context, error flag and registered AW/W/B outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= 4'd0;
      bresp   <= 2'b00;
      w_err   <= 1'b0;
      w_addr  <= 32'd0;
      w_len   <= 4'd0;
      w_beat  <= 4'd0;
      w_size  <= 3'd0;
      w_burst <= 2'd0;
    end else begin
      w_state <= w_next;
      awready <= (w_next == W_IDLE);
      wready  <= (w_next == W_DATA);
      bvalid  <= (w_next == W_RESP);
      if (aw_hs) begin
        bid     <= awid;
        w_addr  <= awaddr;
        w_len   <= awlen;
        w_size  <= awsize;
        w_burst <= awburst;
        w_beat  <= 4'd0;
        w_err   <= 1'b0;
      end else if (w_hs) begin
        w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
        w_beat <= w_beat + 4'd1;
        w_err  <= w_err | w_err_beat;
        if (w_last_beat) begin
          bresp <= (w_err | w_err_beat) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  // SRAM byte-lane write port; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && w_hs) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[w_addr[DEPTH_LOG2+1:2]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave against a burst-level memory model.
module tb_axi_sram_slave;

  localparam int unsigned DEPTH_LOG2 = 16;

  logic        clk, rst;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [3:0]  arlen, awlen, arcache, awcache, wstrb;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  axi_sram_slave #(.DEPTH_LOG2(DEPTH_LOG2), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [int unsigned];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  int unsigned rr_pat [$];
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 2) & ((32'd1 << DEPTH_LOG2) - 32'd1);
  endfunction

  // Byte address of beat k, straight from the burst-type definitions
  function automatic logic [31:0] beat_addr(input logic [31:0] addr, input int unsigned len,
                                            input int unsigned size, input int unsigned burst,
                                            input int unsigned k);
    int unsigned sz, total, base;
    sz    = 1 << size;
    total = (len + 1) * sz;
    case (burst)
      0:       return addr;
      2: begin
        base = (addr / total) * total;
        return base + ((addr - base + k * sz) % total);
      end
      default: return addr + k * sz;
    endcase
  endfunction

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input int unsigned len,
                            input int unsigned size, input int unsigned burst);
    int t;
    arid = id; araddr = addr; arlen = 4'(len); arsize = 3'(size); arburst = 2'(burst);
    arvalid = 1'b1;
    t = 0;
    while (!arready && t < 20) begin @(posedge clk); #1; t++; end
    check("ar_ready", 32'(arready), 32'd1);
    if (arready !== 1'b1) begin arvalid = 1'b0; return; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      logic [31:0] exp;
      bit done;
      int stall;
      exp = ref_mem[widx(beat_addr(addr, len, size, burst, k))];
      done = 1'b0;
      stall = 0;
      while (!done) begin
        check("r_valid", 32'(rvalid), 32'd1);
        check("r_data", rdata, exp);
        check("r_id", 32'(rid), 32'(id));
        check("r_last", 32'(rlast), 32'(k == int'(len)));
        check("r_resp", 32'(rresp), 32'd0);
        if (rr_pat.size() > 0) rready = 1'(rr_pat.pop_front());
        else if (stall >= 3)   rready = 1'b1;
        else                   rready = 1'($urandom_range(0, 1));
        done = rready;
        last_rdata = rdata;
        @(posedge clk); #1;
        stall++;
      end
    end
    rready = 1'b0;
    check("ar_return", 32'(arready), 32'd1);
    check("r_idle", 32'(rvalid), 32'd0);
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input int unsigned len,
                             input int unsigned size, input int unsigned burst, input int last_at);
    int t;
    logic rdy;
    logic [31:0] a;
    awid = id; awaddr = addr; awlen = 4'(len); awsize = 3'(size); awburst = 2'(burst);
    awvalid = 1'b1;
    t = 0;
    while (!awready && t < 20) begin @(posedge clk); #1; t++; end
    check("aw_ready", 32'(awready), 32'd1);
    if (awready !== 1'b1) begin awvalid = 1'b0; return; end
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("w_ready", 32'(wready), 32'd1);
    for (int k = 0; k <= int'(len); k++) begin
      for (int g = 0; g < 2 && $urandom_range(0, 3) == 0; g++) begin
        wvalid = 1'b0;
        @(posedge clk); #1;
      end
      a = beat_addr(addr, len, size, burst, k);
      wvalid = 1'b1; wdata = wd[k]; wstrb = ws[k]; wlast = (k == last_at); wid = id;
      rdy = wready;
      @(posedge clk); #1;
      check("w_accept", 32'(rdy), 32'd1);
      for (int i = 0; i < 4; i++)
        if (ws[k][i]) ref_mem[widx(a)][8*i +: 8] = wd[k][8*i +: 8];
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("b_valid", 32'(bvalid), 32'd1);
    check("b_id", 32'(bid), 32'(id));
    check("b_resp", 32'(bresp), (last_at != int'(len)) ? 32'd2 : 32'd0);
    for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
      bready = 1'b0;
      @(posedge clk); #1;
      check("b_hold", 32'(bvalid), 32'd1);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("aw_return", 32'(awready), 32'd1);
    check("b_idle", 32'(bvalid), 32'd0);
  endtask

  initial begin
    int unsigned sz, bt, ln, ad;
    rst = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'd1;
    arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'd1;
    awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    last_rdata = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_rid", 32'(rid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rresp", 32'(rresp), 32'd0);
    check("rst_bid", 32'(bid), 32'd0);
    check("rst_bresp", 32'(bresp), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_arready", 32'(arready), 32'd1);
    check("post_rst_awready", 32'(awready), 32'd1);

    // Fill the working region 0x000-0x3FF with known data
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
      write_burst(4'(b), 32'(b * 64), 15, 2, 1, 15);
    end

    // Single-beat read
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    write_burst(4'h3, 32'h100, 0, 2, 1, 0);
    read_burst(4'h5, 32'h100, 0, 2, 1);
    check("single_rdata", last_rdata, 32'hDEADBEEF);

    // 4-beat INCR read with a fixed rready stall pattern
    rr_pat = '{1, 0, 0, 1, 1, 0, 1};
    read_burst(4'h6, 32'h200, 3, 2, 1);

    // Byte strobes
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    write_burst(4'h9, 32'h300, 0, 2, 1, 0);
    wd[0] = 32'h11223344; ws[0] = 4'b0101;
    write_burst(4'hA, 32'h300, 0, 2, 1, 0);
    read_burst(4'h1, 32'h300, 0, 2, 1);
    check("strobe_rdata", last_rdata, 32'hFF22FF44);

    // WRAP read around a 16-byte block
    read_burst(4'h2, 32'h108, 3, 2, 2);

    // Misplaced wlast, then a clean write
    for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    write_burst(4'h4, 32'h180, 3, 2, 1, 2);
    read_burst(4'h4, 32'h180, 3, 2, 1);
    for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    write_burst(4'h7, 32'h180, 3, 2, 1, 3);
    read_burst(4'h7, 32'h180, 3, 2, 1);

    // Upper address bits alias onto the same word
    read_burst(4'h8, 32'h0004_0100, 0, 2, 1);
    check("alias_rdata", last_rdata, 32'hDEADBEEF);

    // Randomized mixed traffic
    for (int it = 0; it < 40; it++) begin
      sz = $urandom_range(0, 2);
      bt = $urandom_range(0, 3);
      ln = (bt == 2) ? ((32'd1 << $urandom_range(1, 4)) - 1) : $urandom_range(0, 15);
      ad = $urandom_range(0, 32'h300) & ~((32'd1 << sz) - 1);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom); end
        write_burst(4'($urandom), ad, ln, sz, bt,
                    ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : int'(ln));
      end else begin
        read_burst(4'($urandom), ad, ln, sz, bt);
      end
    end

    // Reset in the middle of concurrent read and write bursts
    arid = 4'hC; araddr = 32'h3C0; arlen = 4'd7; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
    awid = 4'hD; awaddr = 32'h380; awlen = 4'd3; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
    check("mid_rst_arready", 32'(arready), 32'd1);
    check("mid_rst_awready", 32'(awready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0;
    check("mid_rst_b0", rdata, ref_mem[widx(32'h3C0)]);
    rready = 1'b1;
    wvalid = 1'b1; wdata = 32'hA5A5_5A5A; wstrb = 4'hF; wlast = 1'b0;
    @(posedge clk); #1;
    ref_mem[widx(32'h380)] = 32'hA5A5_5A5A;
    check("mid_rst_pre", 32'(rvalid), 32'd1);
    rst = 1'b1; rready = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_bvalid", 32'(bvalid), 32'd0);
    check("mid_rst_wready", 32'(wready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_ar_back", 32'(arready), 32'd1);
    check("mid_rst_aw_back", 32'(awready), 32'd1);
    read_burst(4'hE, 32'h380, 3, 2, 1);
    check("mid_rst_kept", last_rdata, ref_mem[widx(32'h38C)]);
    read_burst(4'hE, 32'h380, 0, 2, 1);
    check("mid_rst_written", last_rdata, 32'hA5A5_5A5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
